issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Circular FIFO between the decode and issue stages. Decode writes one instruction entry per cycle; issue reads one per cycle.
- Consumes the pipeline controller's stall and flush outputs: stall_to_id_is, stall_to_is and flash_to_iq.
- Produces the controller's stall_from_decode request while free space is low.
- Is the responder side of the stall/flush control interface.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- WIDTH, 64, entry payload width ({pc[31:0], instr[31:0]}).
- STALL_THRESH, 2, stall_from_decode is asserted when free slots <= STALL_THRESH; covers fetch/decode in-flight latency.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- push_valid  in  1  decode offers an entry this cycle.
- push_data  in  WIDTH  entry payload.
- stall_to_id_is  in  1  controller: suppress push.
- pop_req  in  1  issue consumes head entry this cycle.
- stall_to_is  in  1  controller: suppress pop.
- flash_to_iq  in  1  controller: discard all entries.
- head_valid  out  1  queue non-empty.
- head_data  out  WIDTH  entry at read pointer.
- stall_from_decode  out  1  stall request to controller.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow_err  out  1  sticky: push attempted while full.

Behaviour:
- State: rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register; storage array; overflow_err flag.
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0, overflow_err=0. Outputs: head_valid=0, stall_from_decode=0. Storage contents are don't-care and are not reset.
- push_en = push_valid & ~stall_to_id_is & ~flash_to_iq & (count<DEPTH | pop_en).
- pop_en = pop_req & ~stall_to_is & ~flash_to_iq & (count!=0).
- Push: write storage[wr_ptr]=push_data, then wr_ptr+1.
- Pop: rd_ptr+1.
- Count update: count + push_en - pop_en.
- Latency: a pushed entry appears at head_data/head_valid on the next cycle. There is no same-cycle bypass, so pop_req while empty has no effect even if a push happens in that cycle.
- Full with simultaneous push and pop: both complete and count stays DEPTH.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- head_valid = (count!=0). head_data = storage[rd_ptr], combinational from registered state.
- stall_from_decode = (DEPTH - count) <= STALL_THRESH. It is derived only from registered count, with no combinational path from any input.
- Flush (flash_to_iq=1): highest priority. On the next edge rd_ptr=wr_ptr=0 and count=0; same-cycle push and pop are dropped. overflow_err is unaffected. head_valid=0 from the following cycle.
- Stall inputs only gate push_en/pop_en; pointers hold. Both stalls asserted together freeze the queue.
- Overflow: push_valid & ~stall_to_id_is & ~flash_to_iq & count==DEPTH & ~pop_en sets overflow_err=1, which stays set until rst. The entry is dropped and no state changes.
- Reset mid-operation: immediate return to the reset state regardless of clk; queued entries are lost.

Decomposition:
- Shared package: iq_entry_t packed struct {pc, instr}. WIDTH default equals $bits(iq_entry_t).
- IQ_DEPTH default constant lives alongside the existing global true/false defines.
- No sub-module: pointer/count logic and the storage array stay in one always_ff plus an always_comb. The block is small enough that splitting adds nothing.

Test Plan:
- Reset, then push 0x0000_1000_2402_0001 with no pop: next cycle head_valid=1, head_data=that value, count=1, stall_from_decode=0.
- Push 6 entries with no pop (DEPTH=8, STALL_THRESH=2): stall_from_decode rises in the cycle count becomes 6. A 7th and 8th push reach count=8. A 9th push sets overflow_err=1 and count stays 8.
- Fill to 8, then push and pop simultaneously for 10 cycles with incrementing payloads: count stays 8, head_data follows FIFO order across wrap-around, overflow_err stays 0.
- Count=5; assert flash_to_iq together with push_valid and pop_req: next cycle count=0, head_valid=0, stall_from_decode=0. A subsequent push appears at head next cycle.
- Count=3; hold stall_to_is=1 with pop_req=1 for 4 cycles: count stays 3. Then stall_to_id_is=1 with push_valid=1: no push accepted.
- Count=4; assert rst asynchronously between clock edges: head_valid and count go to 0 immediately, and the queue operates normally after rst deasserts.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared types and defaults for the decode-to-issue instruction queue.
// Global true/false constants live here next to the queue depth default.
package issue_queue_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam int IQ_DEPTH        = 8;
    localparam int IQ_STALL_THRESH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode/issue data path plus the controller's stall/flush handshake for the issue queue.
// The queue is the slave (responder); decode, issue and the controller together form the master.
interface issue_queue_if
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int WIDTH = $bits(iq_entry_t)
);

    logic                        push_valid;
    logic [WIDTH-1:0]            push_data;
    logic                        stall_to_id_is;
    logic                        pop_req;
    logic                        stall_to_is;
    logic                        flash_to_iq;
    logic                        head_valid;
    logic [WIDTH-1:0]            head_data;
    logic                        stall_from_decode;
    logic [cnt_width(DEPTH)-1:0] count;
    logic                        overflow_err;

    modport master (
        output push_valid, push_data, stall_to_id_is,
        output pop_req, stall_to_is, flash_to_iq,
        input  head_valid, head_data, stall_from_decode, count, overflow_err
    );

    modport slave (
        input  push_valid, push_data, stall_to_id_is,
        input  pop_req, stall_to_is, flash_to_iq,
        output head_valid, head_data, stall_from_decode, count, overflow_err
    );

endinterface

// File: rtl/issue_queue.sv
// Circular FIFO between decode and issue with controller stall/flush gating,
// an early stall request on low free space and a sticky overflow flag.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH        = IQ_DEPTH,
    parameter int WIDTH        = $bits(iq_entry_t),
    parameter int STALL_THRESH = IQ_STALL_THRESH
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave iq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;

    logic             full;
    logic             empty;
    logic             push_try;
    logic             push_en;
    logic             pop_en;
    logic [CNT_W-1:0] free_slots;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Flush outranks everything; a pop frees a slot in the same cycle so a full queue can still accept.
    assign push_try = iq.push_valid & ~iq.stall_to_id_is & ~iq.flash_to_iq;
    assign pop_en   = iq.pop_req & ~iq.stall_to_is & ~iq.flash_to_iq & ~empty;
    assign push_en  = push_try & (~full | pop_en);

    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        if (iq.flash_to_iq) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end

        if (push_try && full && !pop_en) begin
            overflow_next = TRUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= FALSE;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Payload storage carries no reset so it can map onto distributed/block memory.
    always_ff @(posedge clk) begin
        if (push_en) begin
            storage[wr_ptr_reg] <= iq.push_data;
        end
    end

    assign free_slots = CNT_W'(DEPTH) - count_reg;

    assign iq.head_valid        = ~empty;
    assign iq.head_data         = storage[rd_ptr_reg];
    assign iq.stall_from_decode = (free_slots <= CNT_W'(STALL_THRESH));
    assign iq.count             = count_reg;
    assign iq.overflow_err      = overflow_reg;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 64;
    localparam int THRESH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    issue_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) iq_bus ();

    issue_queue #(
        .DEPTH       (DEPTH),
        .WIDTH       (WIDTH),
        .STALL_THRESH(THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .iq (iq_bus)
    );

    logic [WIDTH-1:0] model_q[$];
    bit               model_ovf;
    int               checks_total  = 0;
    int               checks_passed = 0;
    int               cyc           = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input bit pv, input logic [63:0] pd, input bit sid,
                         input bit pr, input bit sis, input bit fl);
        iq_bus.push_valid     = pv;
        iq_bus.push_data      = pd;
        iq_bus.stall_to_id_is = sid;
        iq_bus.pop_req        = pr;
        iq_bus.stall_to_is    = sis;
        iq_bus.flash_to_iq    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, 64'(iq_bus.count), 64'(model_q.size()));
        check({tag, ".head_valid"}, 64'(iq_bus.head_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check({tag, ".head_data"}, iq_bus.head_data, model_q[0]);
        end
        check({tag, ".stall"}, 64'(iq_bus.stall_from_decode), 64'((DEPTH - model_q.size()) <= THRESH));
        check({tag, ".ovf"}, 64'(iq_bus.overflow_err), 64'(model_ovf));
    endtask

    // One clock: model the transaction from the spec's rules, advance, then compare.
    task automatic cycle(input string tag);
        bit               do_pop;
        bit               do_push;
        bit               want_push;
        logic [WIDTH-1:0] pdata;
        want_push = iq_bus.push_valid && !iq_bus.stall_to_id_is && !iq_bus.flash_to_iq;
        do_pop    = iq_bus.pop_req && !iq_bus.stall_to_is && !iq_bus.flash_to_iq && (model_q.size() != 0);
        do_push   = want_push && ((model_q.size() < DEPTH) || do_pop);
        pdata     = iq_bus.push_data;
        $display("cyc %0d %s pv=%0b pr=%0b sid=%0b sis=%0b fl=%0b data=%h count_before=%0d",
                 cyc, tag, iq_bus.push_valid, iq_bus.pop_req, iq_bus.stall_to_id_is,
                 iq_bus.stall_to_is, iq_bus.flash_to_iq, pdata, model_q.size());
        if (want_push && !do_push) model_ovf = 1'b1;
        if (iq_bus.flash_to_iq) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(pdata);
        end
        @(posedge clk);
        #1;
        cyc++;
        compare_all(tag);
    endtask

    // Assert reset between clock edges and check that it takes effect without a clock.
    task automatic async_reset(input string tag);
        idle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        $display("cyc %0d %s async reset asserted", cyc, tag);
        compare_all({tag, ".rst"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_n(input string tag, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            cycle(tag);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_ovf = 1'b0;
        #1;
        compare_all("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single push appears at head next cycle.
        drive(1'b1, 64'h0000_1000_2402_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("single_push");
        check("single_push.value", iq_bus.head_data, 64'h0000_1000_2402_0001);
        idle();
        cycle("single_idle");

        // Fill past full: stall rises at count 6, ninth push overflows.
        async_reset("fill");
        push_n("fill", 9, 64'h100);
        check("fill.count8", 64'(iq_bus.count), 64'd8);
        check("fill.ovf_set", 64'(iq_bus.overflow_err), 64'd1);

        // Full queue with simultaneous push/pop across pointer wrap.
        async_reset("wrap");
        push_n("wrap_fill", 8, 64'h200);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h300 + 64'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            cycle("wrap");
        end
        idle();

        // Flush drops same-cycle push and pop.
        async_reset("flush");
        push_n("flush_fill", 5, 64'h400);
        drive(1'b1, 64'h4ff, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("flush");
        check("flush.count0", 64'(iq_bus.count), 64'd0);
        push_n("flush_after", 1, 64'h500);

        // Stalls gate pop and push independently.
        async_reset("stall");
        push_n("stall_fill", 3, 64'h600);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle("stall_pop");
        end
        drive(1'b1, 64'h6ff, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("stall_push");
        check("stall.count3", 64'(iq_bus.count), 64'd3);
        idle();

        // Mid-operation asynchronous reset, then normal traffic.
        push_n("rst_fill", 1, 64'h700);
        check("rst_fill.count4", 64'(iq_bus.count), 64'd4);
        async_reset("mid");
        push_n("post_rst", 2, 64'h800);
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("post_rst_pop");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199) == 0) begin
                async_reset("rand");
            end
            drive($urandom_range(99) < 60, {$urandom, $urandom}, $urandom_range(99) < 15,
                  $urandom_range(99) < 50, $urandom_range(99) < 15, $urandom_range(99) < 3);
            cycle("rand");
        end
        idle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
